ecc_alu_seq: RTL
================

Name: ecc_alu_seq

Overview:
- Command sequencer for the GF(2^163) ALU: the initiator side of the ALU operand/result interface.
- Holds an NREG-entry 163-bit operand register file.
- Accepts one field-operation command at a time over a valid/ready handshake, drives DA/DB/Mul_enable/SQA_opt, waits the op-specific ALU latency, and writes the selected result back to the register file.
- Sits between the point-arithmetic controller (above) and the ALU (below).

Parameters:
- NREG, 8, number of 163-bit registers; power of 2, ≥2.
- AW, 3, register address width, = log2(NREG).
- MUL_LAT, 4, cycles from operands on DA/DB (Mul_enable=1) to valid BP_OUT1; 1..255.
- SQA_LAT, 1, cycles from operands/SQA_opt to valid BP_OUT2; 1..255.
- SS_LAT, 1, cycles from DB to valid SS_OUT; 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 MUL, 01 ADD, 10 ADDSQ, 11 SQSQ.
- cmd_ra  in  AW  source A register.
- cmd_rb  in  AW  source B register.
- cmd_rd  in  AW  destination register.
- ld_en  in  1  host register write.
- ld_addr  in  AW  host write address.
- ld_data  in  163  host write data.
- rd_addr  in  AW  host read address.
- rd_data  out  163  combinational rf[rd_addr].
- done  out  1  one-cycle pulse; result written at the end of this cycle.
- busy  out  1  = !cmd_ready.
- DA  out  163  ALU operand A, registered.
- DB  out  163  ALU operand B, registered.
- Mul_enable  out  1  ALU multiplier enable, registered.
- SQA_opt  out  1  ALU adder/square select, registered.
- BP_OUT1  in  163  multiplier result.
- BP_OUT2  in  163  adder / adder+square result.
- SS_OUT  in  163  double-square result, of DB.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - DA=DB=0, Mul_enable=0, SQA_opt=0, done=0.
  - All rf entries=0; op/rd latches=0; counter=0.
  - Reset mid-operation aborts the op with no writeback.
- FSM states: IDLE, ISSUE, WAIT, WB. cmd_ready=1 only in IDLE; done=1 only in WB.
- IDLE:
  - On cmd_valid, latch op and rd.
  - DA<=rf[cmd_ra] and DB<=rf[cmd_rb] (pre-write values, even if ld_en targets the same address that cycle).
  - SQA_opt<=(op==ADDSQ); Mul_enable<=(op==MUL).
  - Go to ISSUE.
- ISSUE:
  - Mul_enable<=0, so it is high for exactly the ISSUE cycle.
  - LAT = MUL_LAT / SQA_LAT / SQA_LAT / SS_LAT for MUL / ADD / ADDSQ / SQSQ.
  - If LAT==1, go to WB; else cnt<=LAT-1 and go to WAIT.
- WAIT: cnt<=cnt-1; when cnt==1, go to WB.
- WB:
  - rf[rd]<=BP_OUT1 for MUL, BP_OUT2 for ADD/ADDSQ, SS_OUT for SQSQ.
  - Go to IDLE.
- Operand and select hold:
  - DA, DB and SQA_opt hold from ISSUE through WB.
  - They change only on the next command acceptance.
- Timing: command accepted at the end of cycle 0 → ISSUE in cycle 1 → done in cycle 1+LAT → cmd_ready in cycle 2+LAT.
- Host load (ld_en):
  - Honoured only in IDLE; ignored in ISSUE/WAIT/WB.
  - No collision with WB writeback is possible.
- SQSQ uses only DB (cmd_rb); DA is still loaded from cmd_ra.
- ra==rb==rd is legal; the result overwrites the source after the op.
- cmd_valid held during busy: not accepted until IDLE; the command fields must stay stable.

Test Plan:
- Bench ALU model: MUL_LAT=4 pipeline; XOR adder with optional square, 1-cycle latency; double-square, 1-cycle latency.
- Reset/idle: deassert rst_n mid-MUL (WAIT) → outputs 0, cmd_ready=1 next cycle, rf[rd] unchanged (0), no done.
- ADD: ld r0=0x5, r1=0x3; ADD ra=0 rb=1 rd=2 → DA=0x5, DB=0x3, SQA_opt=0, done 2 cycles after accept, rf[2]=0x6, Mul_enable never high.
- ADDSQ: r0=0x2, r1=0x0; ADDSQ 0,1→3 → SQA_opt=1, rf[3]=0x4 ((0x2⊕0)^2 = x^2).
- MUL: r4=0x2, r5=0x3; MUL 4,5→6 → Mul_enable high exactly 1 cycle, done 5 cycles after accept, rf[6]=0x6, cmd_ready low for 5 cycles.
- SQSQ plus back-to-back:
  - r1=0x2; SQSQ rb=1 rd=1 → rf[1]=0x10 (x^4).
  - cmd_valid held high with a second ADD queued → the second command is accepted in the first IDLE cycle after done.
  - ld_en issued during busy is ignored.
- Same-cycle ld/cmd in IDLE: ld r0=0x7 while ADD 0,0→1 with r0=0x1 → operands use 0x1, rf[1]=0x0, then rf[0]=0x7.

Source files
------------

// File: rtl/ecc_alu_seq_if.sv
// Command, host register-file and ALU operand/result signals of the GF(2^163) sequencer.
// slave = sequencer view; master = controller + ALU view.
interface ecc_alu_seq_if #(
   parameter int AW = 3
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_ra;
   logic [AW-1:0] cmd_rb;
   logic [AW-1:0] cmd_rd;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [162:0]  ld_data;
   logic [AW-1:0] rd_addr;
   logic [162:0]  rd_data;
   logic          done;
   logic          busy;
   logic [162:0]  DA;
   logic [162:0]  DB;
   logic          Mul_enable;
   logic          SQA_opt;
   logic [162:0]  BP_OUT1;
   logic [162:0]  BP_OUT2;
   logic [162:0]  SS_OUT;

   modport slave (
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
      input  ld_en, ld_addr, ld_data, rd_addr,
      input  BP_OUT1, BP_OUT2, SS_OUT,
      output cmd_ready, rd_data, done, busy,
      output DA, DB, Mul_enable, SQA_opt
   );

   modport master (
      output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
      output ld_en, ld_addr, ld_data, rd_addr,
      output BP_OUT1, BP_OUT2, SS_OUT,
      input  cmd_ready, rd_data, done, busy,
      input  DA, DB, Mul_enable, SQA_opt
   );
endinterface

// File: rtl/ecc_alu_seq.sv
// GF(2^163) ALU command sequencer: register file, one-command-at-a-time issue,
// fixed-latency wait and result writeback.
module ecc_alu_seq #(
   parameter int NREG    = 8,
   parameter int AW      = 3,
   parameter int MUL_LAT = 4,
   parameter int SQA_LAT = 1,
   parameter int SS_LAT  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   ecc_alu_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_ADDSQ = 2'b10;
   localparam logic [1:0] OP_SQSQ  = 2'b11;

   state_e        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [162:0]  da_q, da_d;
   logic [162:0]  db_q, db_d;
   logic          mul_q, mul_d;
   logic          sqa_q, sqa_d;
   logic [162:0]  rf_q [NREG];

   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [162:0]  rf_wd;
   logic [7:0]    lat;

   always_comb begin
      case (op_q)
         OP_MUL:  lat = 8'(MUL_LAT);
         OP_SQSQ: lat = 8'(SS_LAT);
         default: lat = 8'(SQA_LAT);
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      da_d    = da_q;
      db_d    = db_q;
      mul_d   = mul_q;
      sqa_d   = sqa_q;
      rf_we   = 1'b0;
      rf_wa   = rd_q;
      rf_wd   = bus.BP_OUT1;
      case (state_q)
         IDLE: begin
            if (bus.ld_en) begin
               rf_we = 1'b1;
               rf_wa = bus.ld_addr;
               rf_wd = bus.ld_data;
            end
            // Operands read rf_q, so a same-cycle host load is not yet visible.
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               rd_d    = bus.cmd_rd;
               da_d    = rf_q[bus.cmd_ra];
               db_d    = rf_q[bus.cmd_rb];
               sqa_d   = (bus.cmd_op == OP_ADDSQ);
               mul_d   = (bus.cmd_op == OP_MUL);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mul_d = 1'b0;
            if (lat == 8'd1) begin
               state_d = WB;
            end else begin
               cnt_d   = lat - 8'd1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = WB;
         end
         WB: begin
            rf_we = 1'b1;
            case (op_q)
               OP_MUL:  rf_wd = bus.BP_OUT1;
               OP_SQSQ: rf_wd = bus.SS_OUT;
               default: rf_wd = bus.BP_OUT2;
            endcase
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         da_q    <= '0;
         db_q    <= '0;
         mul_q   <= 1'b0;
         sqa_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         da_q    <= da_d;
         db_q    <= db_d;
         mul_q   <= mul_d;
         sqa_q   <= sqa_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[rf_wa] <= rf_wd;
      end
   end

   assign bus.cmd_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == WB);
   assign bus.rd_data    = rf_q[bus.rd_addr];
   assign bus.DA         = da_q;
   assign bus.DB         = db_q;
   assign bus.Mul_enable = mul_q;
   assign bus.SQA_opt    = sqa_q;
endmodule
